mult_seq: RTL and testbench

Sequential unsigned shift-and-add multiplier controller that produces a 2N-bit product split into hi and lo halves. It time-shares a single N-bit rc_adder instance over N iterations, using one adder pass per cycle. It sits beside the ALU and serves the MULTU/MFHI/MFLO path, so the core can multiply without a combinational N×N array.

---
 rtl/mult_seq_if.sv | 17 +
 rtl/mult_seq.sv | 109 ++++++++++
 tb/tb_mult_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - multiplier request/result bundle
interface mult_seq_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (output start, output a, output b,
                    input busy, input done, input hi, input lo);
    modport slave  (input start, input a, input b,
                    output busy, output done, output hi, output lo);
endinterface

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential shift-and-add unsigned multiplier, one adder pass per cycle
module rc_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic w_carry;

    always_comb begin
        w_carry = i_cin;
        o_sum   = '0;
        for (int i = 0; i < N; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end
endmodule

module mult_seq #(
    parameter int N = 32
) (
    input  logic      clk,
    input  logic      reset,
    mult_seq_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [N-1:0]    r_mcand;
    logic [N-1:0]    r_acc;
    logic [N-1:0]    r_mplr;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_hi;
    logic [N-1:0]    r_lo;
    logic [N-1:0]    w_sum;
    logic            w_cout;
    logic [2*N-1:0]  w_next_prod;
    logic            w_last;
    logic            w_accept;

    rc_adder #(.N(N)) u_adder (
        .i_a    (r_acc),
        .i_b    (r_mcand),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Adder carry becomes the new top bit; the product shifts right one place per pass.
    assign w_next_prod = r_mplr[0] ? {w_cout, w_sum, r_mplr[N-1:1]}
                                   : {1'b0, r_acc, r_mplr[N-1:1]};
    assign w_last      = (r_cnt == CW'(N - 1));
    assign w_accept    = bus.start && (r_state != S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = bus.start ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next_state = bus.start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_accept) begin
            r_mcand <= bus.a;
            r_acc   <= '0;
            r_mplr  <= bus.b;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc  <= w_next_prod[2*N-1:N];
            r_mplr <= w_next_prod[N-1:0];
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_hi <= w_next_prod[2*N-1:N];
                r_lo <= w_next_prod[N-1:0];
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - directed self-checking bench for mult_seq at N=32 and N=8
module tb_mult_seq;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mult_seq_if #(.N(32)) if32 ();
    mult_seq_if #(.N(8))  if8 ();

    mult_seq #(.N(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    mult_seq #(.N(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one N=32 operation and watches 60 cycles after the accept edge.
    task automatic run_op32(input logic [31:0] a, input logic [31:0] b,
                            output int lat, output int n_done, output int n_busy,
                            output logic [31:0] hi, output logic [31:0] lo);
        lat = 0; n_done = 0; n_busy = 0; hi = '0; lo = '0;
        if32.a = a; if32.b = b; if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (if32.busy) n_busy++;
            if (if32.done) begin
                n_done++;
                if (n_done == 1) begin
                    lat = cyc; hi = if32.hi; lo = if32.lo;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_tests++;
        if ({if32.busy, if32.done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ctrl: got busy/done %b expected 00", {if32.busy, if32.done});
        end
        n_tests++;
        if ({if32.hi, if32.lo} !== 64'h0) begin
            n_fail++; $display("FAIL reset_prod: got %h expected 0", {if32.hi, if32.lo});
        end
    endtask

    task automatic test_basic();
        int lat, nd, nb; logic [31:0] hi, lo;
        run_op32(32'd3, 32'd5, lat, nd, nb, hi, lo);
        n_tests++;
        if (lat !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d expected 33", lat); end
        n_tests++;
        if (nd !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
        n_tests++;
        if (nb !== 32) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 32", nb); end
        n_tests++;
        if ({hi, lo} !== 64'd15) begin n_fail++; $display("FAIL basic_product: got %h expected %h", {hi, lo}, 64'd15); end
    endtask

    task automatic test_zero();
        int lat, nd, nb; logic [31:0] hi, lo;
        run_op32(32'h12345678, 32'h0, lat, nd, nb, hi, lo);
        n_tests++;
        if (lat !== 33 || nd !== 1 || {hi, lo} !== 64'h0) begin
            n_fail++; $display("FAIL zero_b: got lat %0d done %0d prod %h expected 33 1 0", lat, nd, {hi, lo});
        end
        run_op32(32'h0, 32'h9ABCDEF0, lat, nd, nb, hi, lo);
        n_tests++;
        if (lat !== 33 || nd !== 1 || {hi, lo} !== 64'h0) begin
            n_fail++; $display("FAIL zero_a: got lat %0d done %0d prod %h expected 33 1 0", lat, nd, {hi, lo});
        end
    endtask

    task automatic test_max();
        int lat, nd, nb; logic [31:0] hi, lo;
        run_op32(32'hFFFFFFFF, 32'hFFFFFFFF, lat, nd, nb, hi, lo);
        n_tests++;
        if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL max_hi: got %h expected fffffffe", hi); end
        n_tests++;
        if (lo !== 32'h00000001) begin n_fail++; $display("FAIL max_lo: got %h expected 00000001", lo); end
        n_tests++;
        if (lat !== 33) begin n_fail++; $display("FAIL max_latency: got %0d expected 33", lat); end
    endtask

    // Follows test_max, so the held product is fffffffe_00000001.
    task automatic test_start_while_busy();
        int lat = 0, nd = 0, nb = 0, hold_err = 0;
        logic [31:0] hi = '0, lo = '0;
        if32.a = 32'd7; if32.b = 32'd6; if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (if32.busy) nb++;
            if (cyc < 33 && {if32.hi, if32.lo} !== 64'hFFFFFFFE_00000001) hold_err++;
            if (if32.done) begin
                nd++;
                if (nd == 1) begin lat = cyc; hi = if32.hi; lo = if32.lo; end
            end
            if (cyc == 5) begin if32.start = 1'b1; if32.a = 32'd100; if32.b = 32'd100; end
            if (cyc == 6) if32.start = 1'b0;
            tick();
        end
        n_tests++;
        if (hold_err !== 0) begin n_fail++; $display("FAIL busy_hold_prev: got %0d changed cycles expected 0", hold_err); end
        n_tests++;
        if (nd !== 1 || lat !== 33) begin n_fail++; $display("FAIL busy_single_done: got %0d dones at %0d expected 1 at 33", nd, lat); end
        n_tests++;
        if ({hi, lo} !== 64'd42) begin n_fail++; $display("FAIL busy_product: got %h expected %h", {hi, lo}, 64'd42); end
        n_tests++;
        if (nb !== 32) begin n_fail++; $display("FAIL busy_ignored: got %0d busy cycles expected 32", nb); end
    endtask

    task automatic test_reset_mid();
        int lat, nd, nb; logic [31:0] hi, lo;
        int stray = 0;
        if32.a = 32'd9; if32.b = 32'd9; if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({if32.busy, if32.done, if32.hi, if32.lo} !== 66'h0) begin
            n_fail++; $display("FAIL mid_reset_state: got busy %b done %b prod %h expected all 0", if32.busy, if32.done, {if32.hi, if32.lo});
        end
        for (int i = 0; i < 50; i++) begin
            if (if32.done) stray++;
            tick();
        end
        n_tests++;
        if (stray !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d dones expected 0", stray); end
        run_op32(32'd2, 32'd3, lat, nd, nb, hi, lo);
        n_tests++;
        if (lat !== 33 || {hi, lo} !== 64'd6) begin
            n_fail++; $display("FAIL mid_reset_restart: got lat %0d prod %h expected 33 6", lat, {hi, lo});
        end
    endtask

    task automatic test_back_to_back();
        int d1 = 0, d2 = 0, nd = 0, busy10 = 0;
        logic [7:0] hi1 = '0, lo1 = '0, hi2 = '0, lo2 = '0;
        if8.a = 8'hFF; if8.b = 8'hFF; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 10) busy10 = int'(if8.busy);
            if8.start = 1'b0;
            if (if8.done) begin
                nd++;
                if (nd == 1) begin
                    d1 = cyc; hi1 = if8.hi; lo1 = if8.lo;
                    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h10;
                end else if (nd == 2) begin
                    d2 = cyc; hi2 = if8.hi; lo2 = if8.lo;
                end
            end
            tick();
        end
        if8.start = 1'b0;
        n_tests++;
        if (d1 !== 9) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 9", d1); end
        n_tests++;
        if ({hi1, lo1} !== 16'hFE01) begin n_fail++; $display("FAIL b2b_first_product: got %h expected fe01", {hi1, lo1}); end
        n_tests++;
        if (d2 - d1 !== 9) begin n_fail++; $display("FAIL b2b_interval: got %0d expected 9", d2 - d1); end
        n_tests++;
        if ({hi2, lo2} !== 16'h0100) begin n_fail++; $display("FAIL b2b_second_product: got %h expected 0100", {hi2, lo2}); end
        n_tests++;
        if (busy10 !== 1 || nd !== 2) begin n_fail++; $display("FAIL b2b_no_idle: got busy %0d dones %0d expected 1 2", busy10, nd); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1;
        if32.start = 1'b0; if32.a = '0; if32.b = '0;
        if8.start  = 1'b0; if8.a  = '0; if8.b  = '0;
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
